// File: rtl/router_term_src.sv
// Terminal-side packet source: host-fed FIFO presented to a mesh router terminal input,
// with self-addressed drop, sticky misuse flags and a head-of-line stall watchdog.
module router_term_src #(
   parameter int PCK_SZ    = 40,
   parameter int DEPTH     = 8,
   parameter int DST_MSB   = PCK_SZ - 9,
   parameter int DST_LSB   = PCK_SZ - 14,
   parameter int TERM_ID   = 0,
   parameter bit DROP_SELF = 1'b1,
   parameter int STALL_MAX = 128
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [PCK_SZ-1:0]        data_in,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic [PCK_SZ-1:0]        data_out_i_in,
   output logic                     pndng_i_in,
   input  logic                     popin,
   output logic                     overflow,
   output logic                     underflow,
   output logic                     stall,
   output logic [15:0]              self_drop_cnt
);

   localparam int               AW      = $clog2(DEPTH);
   localparam int               CW      = AW + 1;
   localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
   localparam logic [7:0]       STALL_C = 8'(STALL_MAX);

   logic [PCK_SZ-1:0] mem_r [DEPTH];
   logic [AW:0]       wr_ptr_r, rd_ptr_r;
   logic [CW-1:0]     count_r;
   logic              full_r, pndng_r;
   logic [PCK_SZ-1:0] head_r;
   logic [7:0]        wait_cnt_r;
   logic              overflow_r, underflow_r, stall_r;
   logic [15:0]       self_cnt_r;

   logic              self_s, push_ok_s, pop_ok_s, overflow_ev_s, underflow_ev_s;
   logic [AW:0]       wr_ptr_nxt_s, rd_ptr_nxt_s;
   logic [CW-1:0]     count_nxt_s;
   logic [PCK_SZ-1:0] head_nxt_s;
   logic [7:0]        wait_nxt_s;
   logic [15:0]       self_cnt_nxt_s;

   // Handshake decode and next-state computation for pointers, occupancy, head and watchdog.
   always_comb begin
      self_s         = 1'b0;
      push_ok_s      = 1'b0;
      pop_ok_s       = popin & pndng_r;
      underflow_ev_s = popin & ~pndng_r;
      overflow_ev_s  = 1'b0;
      wr_ptr_nxt_s   = wr_ptr_r;
      rd_ptr_nxt_s   = rd_ptr_r;
      count_nxt_s    = count_r;
      head_nxt_s     = '0;
      wait_nxt_s     = wait_cnt_r;
      self_cnt_nxt_s = self_cnt_r;

      if (DROP_SELF && (data_in[DST_MSB:DST_LSB] == 6'(TERM_ID))) begin
         self_s = push;
      end else begin
         self_s = 1'b0;
      end

      // A full FIFO still accepts when the router frees the head on the same edge.
      push_ok_s     = push & ~self_s & (~full_r | popin);
      overflow_ev_s = push & ~self_s & full_r & ~popin;

      if (push_ok_s) begin
         wr_ptr_nxt_s = wr_ptr_r + (AW+1)'(1);
      end else begin
         wr_ptr_nxt_s = wr_ptr_r;
      end

      if (pop_ok_s) begin
         rd_ptr_nxt_s = rd_ptr_r + (AW+1)'(1);
      end else begin
         rd_ptr_nxt_s = rd_ptr_r;
      end

      case ({push_ok_s, pop_ok_s})
         2'b10:   count_nxt_s = count_r + CW'(1);
         2'b01:   count_nxt_s = count_r - CW'(1);
         default: count_nxt_s = count_r;
      endcase

      // The write slot can only coincide with the next head when that entry is the sole one.
      if (count_nxt_s == CW'(0)) begin
         head_nxt_s = '0;
      end else if (push_ok_s && (wr_ptr_r[AW-1:0] == rd_ptr_nxt_s[AW-1:0])) begin
         head_nxt_s = data_in;
      end else begin
         head_nxt_s = mem_r[rd_ptr_nxt_s[AW-1:0]];
      end

      if (!pndng_r || popin) begin
         wait_nxt_s = 8'd0;
      end else if (wait_cnt_r != 8'hFF) begin
         wait_nxt_s = wait_cnt_r + 8'd1;
      end else begin
         wait_nxt_s = wait_cnt_r;
      end

      if (self_s && (self_cnt_r != 16'hFFFF)) begin
         self_cnt_nxt_s = self_cnt_r + 16'd1;
      end else begin
         self_cnt_nxt_s = self_cnt_r;
      end
   end

   // Packet storage; contents are meaningless until indexed by a valid pointer.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= data_in;
      end
   end

   // Control state and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_r    <= '0;
         rd_ptr_r    <= '0;
         count_r     <= '0;
         full_r      <= 1'b0;
         pndng_r     <= 1'b0;
         head_r      <= '0;
         wait_cnt_r  <= 8'd0;
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
         stall_r     <= 1'b0;
         self_cnt_r  <= 16'd0;
      end else begin
         wr_ptr_r    <= wr_ptr_nxt_s;
         rd_ptr_r    <= rd_ptr_nxt_s;
         count_r     <= count_nxt_s;
         full_r      <= (count_nxt_s == DEPTH_C);
         pndng_r     <= (count_nxt_s != CW'(0));
         head_r      <= head_nxt_s;
         wait_cnt_r  <= wait_nxt_s;
         overflow_r  <= overflow_r | overflow_ev_s;
         underflow_r <= underflow_r | underflow_ev_s;
         stall_r     <= stall_r | (wait_nxt_s >= STALL_C);
         self_cnt_r  <= self_cnt_nxt_s;
      end
   end

   assign full          = full_r;
   assign count         = count_r;
   assign pndng_i_in    = pndng_r;
   assign data_out_i_in = head_r;
   assign overflow      = overflow_r;
   assign underflow     = underflow_r;
   assign stall         = stall_r;
   assign self_drop_cnt = self_cnt_r;

endmodule
